// File: rtl/bit_packer.sv
// Serial-to-byte packer: collects MSB-first code bits into bytes and queues them in a 4-entry FIFO.
// Optional macro BIT_PACKER_OVF_STICKY_EN makes overflow sticky until reset (default: per-drop pulse).
module bit_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_data,
    input  logic       in_start,
    input  logic       in_done,
    output logic [7:0] byte_data,
    output logic [3:0] byte_nbits,
    output logic       byte_last,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [7:0]  asm_reg, asm_next;
    logic [7:0]  pend_reg, pend_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [7:0]  asm_with_bit;
    logic        push;
    logic [12:0] push_entry;

    logic [12:0] mem_reg [4];
    logic [1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [2:0]  count_reg;
    logic        full, pop, push_ok, drop;

    assign asm_with_bit = in_data ? (asm_reg | (8'h80 >> cnt_reg)) : asm_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            asm_reg        <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            asm_reg        <= asm_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_start) state_next = COLLECT;
            COLLECT: if (in_done && !in_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A full byte waits in pend_reg until we learn whether it closes the frame,
    // so pend_valid_reg implies cnt_reg == 0 and in_done never needs two pushes.
    always_comb begin
        cnt_next        = cnt_reg;
        asm_next        = asm_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        push            = 1'b0;
        push_entry      = '0;
        case (state_reg)
            IDLE: begin
                if (in_start) begin
                    asm_next = {in_data, 7'b0};
                    cnt_next = 3'd1;
                end
            end
            COLLECT: begin
                if (in_done) begin
                    if (pend_valid_reg) begin
                        push       = 1'b1;
                        push_entry = {pend_reg, 4'd8, 1'b1};
                    end else if (cnt_reg != 3'd0) begin
                        push       = 1'b1;
                        push_entry = {asm_reg, 1'b0, cnt_reg, 1'b1};
                    end
                    pend_valid_next = 1'b0;
                    asm_next        = in_start ? {in_data, 7'b0} : 8'h00;
                    cnt_next        = in_start ? 3'd1 : 3'd0;
                end else begin
                    if (pend_valid_reg) begin
                        push            = 1'b1;
                        push_entry      = {pend_reg, 4'd8, 1'b0};
                        pend_valid_next = 1'b0;
                    end
                    if (cnt_reg == 3'd7) begin
                        pend_next       = asm_with_bit;
                        pend_valid_next = 1'b1;
                        asm_next        = 8'h00;
                        cnt_next        = 3'd0;
                    end else begin
                        asm_next = asm_with_bit;
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_reg == COLLECT) || byte_valid;
    end

    assign full    = (count_reg == 3'd4);
    assign pop     = byte_valid && byte_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem_reg[i] <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= push_entry;
                wr_ptr_reg          <= wr_ptr_reg + 2'd1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + {2'b0, push_ok} - {2'b0, pop};
        end
    end

    assign byte_valid = (count_reg != 3'd0);
    assign {byte_data, byte_nbits, byte_last} = byte_valid ? mem_reg[rd_ptr_reg] : 13'd0;

`ifdef BIT_PACKER_OVF_STICKY_EN
    logic ovf_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_reg <= 1'b0;
        else        ovf_reg <= ovf_reg | drop;
    end
    assign overflow = ovf_reg | drop;
`else
    assign overflow = drop;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: directed frames plus random traffic against a frame-level model.
module tb_bit_packer;

    logic       clk = 1'b0;
    logic       rst_n, in_data, in_start, in_done, byte_ready;
    logic [7:0] byte_data;
    logic [3:0] byte_nbits;
    logic       byte_last, byte_valid, busy, overflow;

    bit_packer dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_start(in_start), .in_done(in_done),
        .byte_data(byte_data), .byte_nbits(byte_nbits), .byte_last(byte_last),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0, ovf_cycles = 0, cyc = 0;
    logic [12:0] exp_q[$];
    logic [12:0] log_q[$];
    bit          ready_rand = 0, prev_stall = 0, cap4 = 0;
    logic [12:0] prev_entry = '0;
    logic [63:0] fb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected entries of one frame: 8-bit chunks, zero-padded tail, last flag on the final chunk.
    task automatic model_frame(input logic [63:0] bits, input int n);
        logic [7:0] d;
        int         nb;
        for (int k = 0; k < n; k += 8) begin
            nb = (n - k > 8) ? 8 : n - k;
            d  = bits[63-k -: 8];
            d  = d & ~(8'hFF >> nb);
            if (!cap4 || exp_q.size() < 4) exp_q.push_back({d, 4'(nb), (k + 8 >= n)});
        end
    endtask

    task automatic step();
        logic [12:0] cur;
        logic [12:0] e;
        cyc++;
        if (ready_rand) byte_ready = ($urandom_range(3) != 0) || (cyc % 4 == 0);
        @(negedge clk);
        cur = {byte_data, byte_nbits, byte_last};
        if (overflow) ovf_cycles++;
        if (prev_stall) check("hold_stable", 32'(cur), 32'(prev_entry));
        if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL pop_unexpected got=%h exp=none", cur);
            end else begin
                e = exp_q.pop_front();
                check("pop_entry", 32'(cur), 32'(e));
            end
            log_q.push_back(cur);
        end
        prev_stall = byte_valid && !byte_ready;
        prev_entry = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            in_start = (i == 0);
            in_data  = bits[63-i];
            step();
        end
        in_start = 1'b0;
    endtask

    task automatic send_done();
        in_done = 1'b1;
        in_data = 1'($urandom);
        step();
        in_done = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] bits, input int n);
        model_frame(bits, n);
        send_bits(bits, n);
        send_done();
    endtask

    task automatic drain();
        int k = 0;
        ready_rand = 0;
        byte_ready = 1'b1;
        while ((exp_q.size() != 0 || byte_valid || busy) && k < 100) begin
            step();
            k++;
        end
        if (k >= 100) begin
            total++;
            bad++;
            $error("FAIL drain_timeout got=%0d exp=0 pending", exp_q.size());
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_data = 1'b0; in_start = 1'b0; in_done = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_data", 32'(byte_data), 32'd0);
        check("rst_nbits", 32'(byte_nbits), 32'd0);
        check("rst_last", 32'(byte_last), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // 5-bit frame 1,0,1,1,0
        log_q.delete();
        byte_ready = 1'b1;
        send_frame({5'b10110, 59'b0}, 5);
        drain();
        check("b0_count", 32'(log_q.size()), 32'd1);
        check("b0_entry", 32'(log_q[0]), 32'({8'hB0, 4'd5, 1'b1}));

        // 8-bit frame A5: pushed in the in_done cycle
        log_q.delete();
        byte_ready = 1'b0;
        model_frame({8'hA5, 56'b0}, 8);
        send_bits({8'hA5, 56'b0}, 8);
        check("a5_before_done", 32'(byte_valid), 32'd0);
        send_done();
        check("a5_after_done", 32'(byte_valid), 32'd1);
        drain();
        check("a5_entry", 32'(log_q[0]), 32'({8'hA5, 4'd8, 1'b1}));

        // 11-bit frame FF then 1,0,1
        log_q.delete();
        send_frame({8'hFF, 3'b101, 53'b0}, 11);
        drain();
        check("f11_count", 32'(log_q.size()), 32'd2);
        check("f11_first", 32'(log_q[0]), 32'({8'hFF, 4'd8, 1'b0}));
        check("f11_second", 32'(log_q[1]), 32'({8'hA0, 4'd3, 1'b1}));

        // coincident in_start/in_done with 2 bits in the partial byte
        log_q.delete();
        fb = {8'h3C, 2'b10, 54'b0};
        model_frame(fb, 10);
        model_frame({3'b101, 61'b0}, 3);
        send_bits(fb, 10);
        in_start = 1'b1; in_done = 1'b1; in_data = 1'b1;
        step();
        check("coinc_busy", 32'(busy), 32'd1);
        in_start = 1'b0; in_done = 1'b0; in_data = 1'b0;
        step();
        in_data = 1'b1;
        step();
        send_done();
        drain();
        check("coinc_count", 32'(log_q.size()), 32'd3);
        check("coinc_old_full", 32'(log_q[0]), 32'({8'h3C, 4'd8, 1'b0}));
        check("coinc_old_tail", 32'(log_q[1]), 32'({8'h80, 4'd2, 1'b1}));
        check("coinc_new", 32'(log_q[2]), 32'({8'hA0, 4'd3, 1'b1}));

        // random frames with random (but never starving) backpressure
        ovf_cycles = 0;
        ready_rand = 1;
        for (int f = 0; f < 20; f++) begin
            fb = {$urandom, $urandom};
            send_frame(fb, $urandom_range(1, 20));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                in_data = 1'($urandom);
                step();
            end
        end
        drain();
        check("rand_no_overflow", 32'(ovf_cycles), 32'd0);

        // six 8-bit frames with byte_ready=0: four kept, two dropped
        log_q.delete();
        ovf_cycles = 0;
        byte_ready = 1'b0;
        cap4 = 1;
        for (int f = 0; f < 6; f++) send_frame({8'($urandom), 56'b0}, 8);
        cap4 = 0;
        step();
        step();
        check("ovf_fifo_held", 32'(byte_valid), 32'd1);
`ifdef BIT_PACKER_OVF_STICKY_EN
        check("ovf_sticky", 32'(overflow), 32'd1);
`else
        check("ovf_pulses", 32'(ovf_cycles), 32'd2);
        check("ovf_pulse_gone", 32'(overflow), 32'd0);
`endif
        drain();
        check("ovf_kept", 32'(log_q.size()), 32'd4);

        // reset after 4 bits, then a 3-bit frame 1,1,1
        log_q.delete();
        send_bits({4'b1011, 60'b0}, 4);
        rst_n = 1'b0;
        #2;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_valid", 32'(byte_valid), 32'd0);
        check("mrst_overflow", 32'(overflow), 32'd0);
        step();
        rst_n = 1'b1;
        prev_stall = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = 1'($urandom);
            step();
            check("mrst_idle_valid", 32'(byte_valid), 32'd0);
            check("mrst_idle_busy", 32'(busy), 32'd0);
        end
        send_frame({3'b111, 61'b0}, 3);
        drain();
        check("mrst_count", 32'(log_q.size()), 32'd1);
        check("mrst_entry", 32'(log_q[0]), 32'({8'hE0, 4'd3, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
